// File: rtl/issue_stage_pkg.sv
// Shared decode layout, opcode map and execute-unit encodings for the issue stage
// and the units that consume its micro-ops.
package issue_stage_pkg;

    typedef struct packed {
        logic [1:0] unit;
        logic [2:0] sub_unit;
        logic [3:0] sel;
        logic       imm;
        logic       csr;
        logic       fence;
        logic       ecall;
        logic       ebreak;
        logic       illegal;
        logic       calc_j;
    } decode_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_LS  = 2'd1;
    localparam logic [1:0] UNIT_CSR = 2'd2;

endpackage

// File: rtl/issue_stage_imm.sv
// Combinational immediate generator: raw instruction to sign-extended XLEN immediate.
// Kept standalone so the branch unit can reuse it.
module imm_gen
    import issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic            csr_imm,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        if (csr_imm) begin
            imm = XLEN'(instr[19:15]);
        end else begin
            case (instr[6:0])
                OP_LUI, OP_AUIPC: imm = XLEN'($signed({instr[31:12], 12'b0}));
                OP_JAL:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                OP_BRANCH: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                OP_STORE:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                OP_LOAD, OP_IMM, OP_JALR: imm = XLEN'($signed(instr[31:20]));
                default:   imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: one-entry holding slot, register scoreboard and hazard check feeding a
// registered micro-op output with valid/ready handshake.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [15:0]     in_decode,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [15:0]     out_decode,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm
);

    logic            slot_valid_q, slot_valid_d;
    logic [31:0]     slot_instr_q, slot_instr_d;
    logic [XLEN-1:0] slot_pc_q, slot_pc_d;
    decode_t         slot_dec_q, slot_dec_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    decode_t         out_dec_q, out_dec_d;
    logic [4:0]      out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_rd_q, out_rd_d;
    logic            out_rd_we_q, out_rd_we_d;
    logic [NREG-1:0] sb_q, sb_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_used, rs2_used, rd_we, serial;
    logic [NREG-1:0] wb_mask, busy_eff;
    logic            operand_haz, serial_haz, hazard, issue, accept;
    logic [XLEN-1:0] slot_imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr  (slot_instr_q),
        .csr_imm(slot_dec_q.csr & slot_dec_q.imm),
        .imm    (slot_imm)
    );

    always_comb begin
        opcode   = slot_instr_q[6:0];
        rs1      = slot_instr_q[19:15];
        rs2      = slot_instr_q[24:20];
        rd       = slot_instr_q[11:7];
        rs1_used = !((opcode == OP_LUI) | (opcode == OP_AUIPC) | (opcode == OP_JAL)
                     | (slot_dec_q.csr & slot_dec_q.imm)
                     | slot_dec_q.fence | slot_dec_q.ecall | slot_dec_q.ebreak);
        rs2_used = (opcode == OP_BRANCH) | (opcode == OP_STORE) | (opcode == OP_REG);
        rd_we    = !((opcode == OP_BRANCH) | (opcode == OP_STORE) | slot_dec_q.fence
                     | slot_dec_q.ecall | slot_dec_q.ebreak | slot_dec_q.illegal)
                   & (rd != 5'd0);
        serial   = slot_dec_q.csr | slot_dec_q.fence | slot_dec_q.ecall | slot_dec_q.ebreak;
        // A writeback landing this cycle already frees its register for the hazard check
        wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
        busy_eff = sb_q & ~wb_mask;
        operand_haz = !slot_dec_q.illegal & ((rs1_used & busy_eff[rs1])
                      | (rs2_used & busy_eff[rs2]) | (rd_we & busy_eff[rd]));
        serial_haz  = serial & ((|busy_eff) | out_valid_q);
        hazard      = operand_haz | serial_haz;
        issue       = slot_valid_q & !hazard & (!out_valid_q | out_ready) & !flush;
        in_ready    = !flush & (!slot_valid_q | issue);
        accept      = in_valid & in_ready;
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        slot_dec_d   = slot_dec_q;
        if (flush) begin
            slot_valid_d = 1'b0;
        end else if (accept) begin
            slot_valid_d = 1'b1;
            slot_instr_d = in_instr;
            slot_pc_d    = in_pc;
            slot_dec_d   = decode_t'(in_decode);
        end else if (issue) begin
            slot_valid_d = 1'b0;
        end

        // Unused source indexes are presented as x0 so execute never forwards on them
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_dec_d   = out_dec_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rd_d    = out_rd_q;
        out_rd_we_d = out_rd_we_q;
        out_imm_d   = out_imm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_pc_d    = slot_pc_q;
            out_dec_d   = slot_dec_q;
            out_rs1_d   = rs1_used ? rs1 : 5'd0;
            out_rs2_d   = rs2_used ? rs2 : 5'd0;
            out_rd_d    = rd;
            out_rd_we_d = rd_we;
            out_imm_d   = slot_imm;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        sb_d = busy_eff;
        if (issue & rd_we) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
            slot_dec_q   <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_dec_q    <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_q     <= '0;
            out_rd_we_q  <= 1'b0;
            out_imm_q    <= '0;
            sb_q         <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            slot_dec_q   <= slot_dec_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_dec_q    <= out_dec_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_rd_q     <= out_rd_d;
            out_rd_we_q  <= out_rd_we_d;
            out_imm_q    <= out_imm_d;
            sb_q         <= sb_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_decode = out_dec_q;
    assign out_rs1    = out_rs1_q;
    assign out_rs2    = out_rs2_q;
    assign out_rd     = out_rd_q;
    assign out_rd_we  = out_rd_we_q;
    assign out_imm    = out_imm_q;

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Sits directly downstream of the instruction decoder. Captures the decoder's 16-bit decode vector together with the full instruction and PC.
- Extracts the register indexes, generates the sign-extended immediate, and tracks pending destination registers in a scoreboard. Stalls on hazards.
- Presents one issued micro-op per cycle to the execute units over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath/immediate/PC width.
- NREG, 32, architectural register count; x0 is never busy.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a decoded instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- in_decode  in  16  decode vector = {unit[15:14], sub_unit[13:11], sel[10:7], imm[6], csr[5], fence[4], ecall[3], ebreak[2], illegal[1], calc_j[0]}.
- flush  in  1  discard slot and output register.
- wb_valid  in  1  a writeback retires rd.
- wb_rd  in  5  retiring register.
- out_valid  out  1  micro-op available.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  registered PC.
- out_decode  out  16  registered decode vector.
- out_rs1  out  5  source 1 index.
- out_rs2  out  5  source 2 index.
- out_rd  out  5  destination index.
- out_rd_we  out  1  destination written.
- out_imm  out  XLEN  generated immediate.

Behaviour:
- Reset (async, rst=1): slot_valid=0, out_valid=0, scoreboard=0. All out_* data outputs reset to 0. in_ready=1 after reset.
- Datapath: a one-entry holding slot feeds an output register.
  - in_ready = !slot_valid | issue.
  - Accept when in_valid & in_ready.
  - issue = slot_valid & !hazard & (!out_valid | out_ready).
- Latency: an accepted instruction appears on out_valid the next cycle if no hazard. Back-to-back issue gives 1 instr/cycle throughput.
- Immediate selection by opcode[6:0]. All immediates are sign-extended to XLEN.
  - U (LUI/AUIPC): instr[31:12]<<12.
  - J (JAL): J-format.
  - B (branches): B-format.
  - S (stores): S-format.
  - I (loads, OP-IMM, JALR): I-format.
  - CSR with imm=1: zero-extended instr[19:15].
  - Others: 0.
- Register usage:
  - rs1 is used unless the instruction is LUI/AUIPC/JAL, CSR-immediate, fence, ecall or ebreak.
  - rs2 is used for branches, stores and register-register ALU ops.
  - rd_we = 0 for branches, stores, fence, ecall, ebreak, illegal, and whenever rd=0.
- Scoreboard: NREG bits; bit0 is hardwired 0.
  - busy_eff = scoreboard & ~(wb_valid ? onehot(wb_rd) : 0).
  - hazard = (rs1 used & busy_eff[rs1]) | (rs2 used & busy_eff[rs2]) | (rd_we & busy_eff[rd]).
  - On issue with rd_we, set bit rd. On wb_valid, clear bit wb_rd.
  - Same-cycle set and clear of the same register: set wins.
- Serialization: instructions with csr, fence, ecall or ebreak set issue only when scoreboard==0 and !out_valid.
- Illegal instructions are not stalled on operands. They issue with rd_we=0 and the illegal bit preserved for the exception path.
- Output hold: while out_valid & !out_ready, all out_* outputs stay stable.
- Flush: next edge sets slot_valid=0 and out_valid=0; the scoreboard is untouched because older in-flight ops still write back. An in_valid arriving in the same cycle as flush is dropped; in_ready is forced to 0 during flush.
- Reset mid-operation: everything clears immediately; any pending writebacks are ignored.

Decomposition:
- cpu_parameters package additions:
  - decode_t packed struct matching the 16-bit layout above.
  - Opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM.
  - Unit encodings: UNIT_ALU=0, UNIT_LS=1, UNIT_CSR=2.
- Sub-module: imm_gen, combinational immediate generator (instr → XLEN immediate), reusable by the branch unit.

Test Plan:
- ADDI x5,x0,7 then ADD x6,x5,x5 with no writeback → ADD stalls and out_valid=0. Inject wb_valid, wb_rd=5 → ADD issues in that same cycle's evaluation and appears on the next cycle.
- SW x1,-4(x2) → out_imm=0xFFFFFFFC, out_rd_we=0, scoreboard unchanged.
- LUI x3,0x12345 → out_imm=0x12345000, out_rs1 marked unused, scoreboard bit3 set.
- out_ready=0 for 3 cycles with 2 queued instructions → outputs stable, in_ready=0 once the slot fills, no loss or duplication after release.
- CSRRW issued with scoreboard bit7 busy → no issue until wb_rd=7; flush asserted mid-stall → out_valid=0, scoreboard bit7 retained.
- Illegal decode (bit1 set) with rs1 busy → issues next cycle with rd_we=0, illegal bit set.
